// File: rtl/reset_seq.sv
// Ordered multi-stage reset generator: HOLD, wait for filtered PLL lock, then release stages 0..NRST-1 DLY cycles apart.
// Optional macro RESET_SEQ_REVERSE_ASSERT_EN: a reset cause in RUN re-asserts the stages in reverse order.

module reset_seq #(
  parameter int NRST     = 4,
  parameter int DLY      = 16,
  parameter int HOLD     = 8,
  parameter int LOCK_FLT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lock_in,
  input  logic            srst_req,
  output logic [NRST-1:0] rst_out,
  output logic            rst_done,
  output logic            seq_busy
);

  localparam int CMAX  = (DLY > HOLD) ? DLY : HOLD;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam int FLT_W = $clog2(LOCK_FLT + 1);
  localparam int IDX_W = (NRST > 1) ? $clog2(NRST) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(DLY - 1);
  localparam logic [FLT_W-1:0] FLT_LAST  = FLT_W'(LOCK_FLT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NRST - 1);

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
    , S_ASSERT  = 3'd4
`endif
  } state_t;

  logic [1:0]       rst_sync_q;
  logic [1:0]       lock_sync_q;
  logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
  logic             lock_ok_q, lock_ok_d;
  logic             lock_s;
  logic             lock_fall;
  logic             cause;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [NRST-1:0]  rst_out_q;
  logic             done_q;
  logic             busy_q;

  // Async assert, 2-flop synchronised release of the internal reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign lock_s = lock_sync_q[1];

  always_comb begin
    flt_cnt_d = flt_cnt_q;
    lock_ok_d = lock_ok_q;
    if (!lock_s) begin
      flt_cnt_d = '0;
      lock_ok_d = 1'b0;
    end else if (!lock_ok_q) begin
      if (flt_cnt_q == FLT_LAST) begin
        lock_ok_d = 1'b1;
      end else begin
        flt_cnt_d = flt_cnt_q + FLT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_q <= 2'b00;
      flt_cnt_q   <= '0;
      lock_ok_q   <= 1'b0;
    end else if (!rst_sync_q[1]) begin
      lock_sync_q <= 2'b00;
      flt_cnt_q   <= '0;
      lock_ok_q   <= 1'b0;
    end else begin
      lock_sync_q <= {lock_sync_q[0], lock_in};
      flt_cnt_q   <= flt_cnt_d;
      lock_ok_q   <= lock_ok_d;
    end
  end

  // Loss of lock is unfiltered: the first low synced sample is a cause.
  assign lock_fall = lock_ok_q & ~lock_s;
  assign cause     = srst_req | lock_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else if (!rst_sync_q[1]) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cause) begin
            cnt_q <= '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_WAIT_LOCK: begin
          if (cause) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
          end else if (lock_ok_q) begin
            state_q <= S_RELEASE;
            cnt_q   <= '0;
            idx_q   <= '0;
          end
        end

        S_RELEASE: begin
          if (cause) begin
            state_q   <= S_HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
          end else if (cnt_q == DLY_LAST) begin
            rst_out_q[idx_q] <= 1'b0;
            cnt_q            <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= S_RUN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_RUN: begin
          if (cause) begin
            done_q <= 1'b0;
            busy_q <= 1'b1;
            cnt_q  <= '0;
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
            // Highest stage goes first; a single-stage build has nothing left to sequence.
            rst_out_q[NRST-1] <= 1'b1;
            if (NRST == 1) begin
              state_q <= S_HOLD;
              idx_q   <= '0;
            end else begin
              state_q <= S_ASSERT;
              idx_q   <= IDX_W'(NRST - 2);
            end
`else
            rst_out_q <= '1;
            state_q   <= S_HOLD;
            idx_q     <= '0;
`endif
          end
        end

`ifdef RESET_SEQ_REVERSE_ASSERT_EN
        S_ASSERT: begin
          if (lock_fall) begin
            state_q   <= S_HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
          end else if (cnt_q == DLY_LAST) begin
            rst_out_q[idx_q] <= 1'b1;
            cnt_q            <= '0;
            if (idx_q == '0) begin
              state_q <= S_HOLD;
            end else begin
              idx_q <= idx_q - IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif

        default: begin
          state_q   <= S_HOLD;
          cnt_q     <= '0;
          idx_q     <= '0;
          rst_out_q <= '1;
          done_q    <= 1'b0;
          busy_q    <= 1'b1;
        end
      endcase
    end
  end

  assign rst_out  = rst_out_q;
  assign rst_done = done_q;
  assign seq_busy = busy_q;

endmodule

// File: tb/tb_reset_seq.sv
// Self-checking bench for reset_seq: directed scenarios plus randomized srst/lock-loss traffic against
// an event-time reference model (release/hold edges computed arithmetically from the sequence rules).

module tb_reset_seq;

  localparam int NRST     = 4;
  localparam int DLY      = 16;
  localparam int HOLD     = 8;
  localparam int LOCK_FLT = 4;

  logic            clk = 1'b0;
  logic            clk_en = 1'b1;
  logic            rst_n = 1'b1;
  logic            lock_in = 1'b0;
  logic            srst_req = 1'b0;
  logic [NRST-1:0] rst_out;
  logic            rst_done;
  logic            seq_busy;

  reset_seq #(
    .NRST(NRST), .DLY(DLY), .HOLD(HOLD), .LOCK_FLT(LOCK_FLT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .lock_in(lock_in), .srst_req(srst_req),
    .rst_out(rst_out), .rst_done(rst_done), .seq_busy(seq_busy)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: edge index n counts from t0 (n = 0).
  int n;
  int hold_at;   // edge at which HOLD was (re)entered with a fresh count
  int rel_at;    // edge at which RELEASE was entered, -1 if not releasing/running
  int asrt_at;   // edge at which reverse assertion began, -1 if not asserting
  bit lin[$];    // lock_in as captured at each edge since t0

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  function automatic bit lso(input int m);
    if (m >= 3) return lin[m-2];
    return 1'b0;
  endfunction

  // Locked after edge m when the last LOCK_FLT synced samples were all high.
  function automatic bit lock_ok_at(input int m);
    for (int k = 0; k < LOCK_FLT; k++) begin
      if (m - k < 1) return 1'b0;
      if (!lso(m - k)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_step(input bit s);
    bit fall;
    bit cause;
    fall  = lock_ok_at(n - 1) && !lso(n);
    cause = s || fall;
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
    if (asrt_at >= 0) begin
      if (fall || n == asrt_at + (NRST - 1) * DLY) begin
        hold_at = n;
        asrt_at = -1;
      end
      return;
    end
    if (cause && rel_at >= 0 && (n - 1) >= rel_at + NRST * DLY) begin
      rel_at = -1;
      if (NRST == 1) hold_at = n;
      else asrt_at = n;
      return;
    end
`endif
    if (cause) begin
      hold_at = n;
      rel_at  = -1;
    end else if (rel_at < 0 && n >= hold_at + HOLD + 1 && lock_ok_at(n - 1)) begin
      rel_at = n;
    end
  endfunction

  function automatic logic [31:0] expected();
    logic [NRST-1:0] r;
    logic done;
    r    = '1;
    done = 1'b0;
    if (asrt_at >= 0) begin
      for (int i = 0; i < NRST; i++) r[i] = (n >= asrt_at + (NRST - 1 - i) * DLY);
    end else if (rel_at >= 0) begin
      for (int i = 0; i < NRST; i++) r[i] = (n < rel_at + (i + 1) * DLY);
      done = (n >= rel_at + NRST * DLY);
    end
    return 32'({!done, done, r});
  endfunction

  function automatic logic [31:0] outv();
    return 32'({seq_busy, rst_done, rst_out});
  endfunction

  task automatic tick(input bit s, input bit l);
    srst_req = s;
    lock_in  = l;
    @(posedge clk);
    n++;
    lin.push_back(l);
    model_step(s);
    @(negedge clk);
    check("seq", outv(), expected());
    srst_req = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after t0.
  task automatic do_reset(input bit l);
    rst_n    = 1'b0;
    lock_in  = l;
    srst_req = 1'b0;
    #1;
    check("rst_async", outv(), 32'h2F);
    repeat (5) @(negedge clk);
    check("rst_hold", outv(), 32'h2F);
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    n       = 0;
    hold_at = 0;
    rel_at  = -1;
    asrt_at = -1;
    lin.delete();
    lin.push_back(1'b0);
    @(negedge clk);
    check("t0", outv(), 32'h2F);
  endtask

  int base_k;
  int low_left;

  initial begin
    #1 rst_n = 1'b0;
    #1 check("por", outv(), 32'h2F);
    @(negedge clk);

    // Lock already high: fixed release schedule from t0.
    do_reset(1'b1);
    for (int k = 1; k <= 80; k++) begin
      tick(1'b0, 1'b1);
      if (k == 24) check("t1_k24", 32'(rst_out), 32'hF);
      if (k == 25) check("t1_k25", 32'(rst_out), 32'hE);
      if (k == 41) check("t1_k41", 32'(rst_out), 32'hC);
      if (k == 57) check("t1_k57", 32'(rst_out), 32'h8);
      if (k == 72) check("t1_done72", 32'(rst_done), 32'h0);
      if (k == 73) check("t1_k73", outv(), 32'h10);
    end

    // Late lock: release gated on the filtered lock.
    do_reset(1'b0);
    for (int k = 1; k <= 200; k++) begin
      tick(1'b0, k >= 100);
      if (k == 121) check("t2_k121", 32'(rst_out), 32'hF);
      if (k == 122) check("t2_k122", 32'(rst_out), 32'hE);
    end
    check("t2_run", 32'(rst_done), 32'h1);

    // Software reset in RUN.
    tick(1'b1, 1'b1);
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
    check("t3_rev0", 32'(rst_out), 32'h8);
    for (int k = 1; k <= 48; k++) begin
      tick(1'b0, 1'b1);
      if (k == 16) check("t3_rev16", 32'(rst_out), 32'hC);
      if (k == 32) check("t3_rev32", 32'(rst_out), 32'hE);
      if (k == 48) check("t3_rev48", 32'(rst_out), 32'hF);
    end
`else
    check("t3_srst", outv(), 32'h2F);
`endif
    for (int k = 1; k <= 25; k++) begin
      tick(1'b0, 1'b1);
      if (k == 24) check("t3_k24", 32'(rst_out), 32'hF);
      if (k == 25) check("t3_k25", 32'(rst_out), 32'hE);
    end

    // One-cycle lock drop while index = 2, then recovery and RUN.
    for (int k = 1; k <= 110; k++) begin
      tick(1'b0, k != 21);
      if (k == 22) check("t4_before", 32'(rst_out), 32'hC);
      if (k == 23) check("t4_reassert", outv(), 32'h2F);
      if (k == 47) check("t4_k47", 32'(rst_out), 32'hF);
      if (k == 48) check("t4_k48", 32'(rst_out), 32'hE);
    end
    check("t5_run", 32'(rst_done), 32'h1);

    // Async reset with the clock stopped.
    clk_en = 1'b0;
    #3 rst_n = 1'b0;
    #1 check("t5_async", outv(), 32'h2F);
    clk_en = 1'b1;
    @(negedge clk);

    // Randomized srst pulses and lock drops.
    do_reset(1'b1);
    low_left = 0;
    for (int k = 0; k < 3000; k++) begin
      base_k = int'($urandom_range(0, 199));
      if (low_left > 0) begin
        low_left--;
        tick(($urandom_range(0, 59) == 0), 1'b0);
      end else if (base_k == 0) begin
        low_left = int'($urandom_range(1, 12));
        tick(1'b0, 1'b0);
      end else begin
        tick(($urandom_range(0, 59) == 0), 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
